// File: rtl/multihat_pkg.sv
// Shared types and helpers for the multi-channel multihat Gaussian generator.
// Holds the FSM state enum, seeding constants and the hat-sum sampler.
package multihat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        WARM,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [63:0] GOLDEN     = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] SUBST_SEED = 64'h0123456789ABCDEF;

    // Centred Irwin-Hall sum, left-aligned in 19 bits so that the
    // caller's OUT_W MSBs are always bits [18 -: OUT_W].
    function automatic logic [18:0] sum_hats(input logic [63:0] x,
                                             input int hats);
        logic [18:0] sum;
        logic [18:0] c;
        int          sw;
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < hats) begin
                sum = sum + 19'(x[16*k +: 16]);
            end
        end
        c  = sum - (19'(hats) << 15);
        sw = (hats > 2) ? 19 : ((hats > 1) ? 18 : 17);
        return c << (19 - sw);
    endfunction

endpackage

// File: rtl/multihat_grng_mc_if.sv
// Control and sample-stream bundle of the multihat generator.
// master drives requests and out_ready, slave returns status and samples.
interface multihat_grng_mc_if #(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 16
);
    logic                    ap_start;
    logic                    ap_stop;
    logic [15:0]             burst_len;
    logic [63:0]             seed_V;
    logic                    out_ready;
    logic                    ap_idle;
    logic                    ap_ready;
    logic                    ap_done;
    logic [NUM_CH*OUT_W-1:0] out_V;
    logic                    out_V_ap_vld;

    modport master (
        output ap_start, ap_stop, burst_len, seed_V, out_ready,
        input  ap_idle, ap_ready, ap_done, out_V, out_V_ap_vld
    );

    modport slave (
        input  ap_start, ap_stop, burst_len, seed_V, out_ready,
        output ap_idle, ap_ready, ap_done, out_V, out_V_ap_vld
    );
endinterface

// File: rtl/multihat_xorshift64.sv
// One xorshift64 uniform generator with synchronous load and step.
// Load wins over step; the state holds when neither is asserted.
module multihat_xorshift64 (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        step,
    output logic [63:0] state
);
    logic [63:0] state_q;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] state_d;

    assign a       = state_q ^ (state_q << 13);
    assign b       = a ^ (a >> 7);
    assign state_d = b ^ (b << 17);
    assign state   = state_q;

    // Generator register: reseed, advance, or hold.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= seed;
        end else if (step) begin
            state_q <= state_d;
        end
    end
endmodule

// File: rtl/multihat_grng_mc.sv
// NUM_CH parallel approximate-Gaussian generators with burst/continuous
// run control, early stop, output backpressure and warm-up discard.
module multihat_grng_mc
    import multihat_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 16,
    parameter int HATS   = 4,
    parameter int WARMUP = 8
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    multihat_grng_mc_if.slave bus
);
    state_t                  state_q;
    logic [63:0]             seed_q;
    logic [15:0]             burst_q;
    logic [15:0]             cnt_q;
    logic [15:0]             warm_q;
    logic [NUM_CH*OUT_W-1:0] out_q;
    logic                    vld_q;
    logic                    ready_q;
    logic                    done_q;
    logic [NUM_CH*OUT_W-1:0] samp;
    logic [63:0]             st [NUM_CH];
    logic                    load;
    logic                    step;
    logic                    launch;

    // A stop request in RUN suppresses that cycle's launch.
    assign launch = (state_q == RUN) && !bus.ap_stop &&
                    (!vld_q || bus.out_ready);
    assign load   = (state_q == SEED);
    assign step   = (state_q == WARM) || launch;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [63:0] SALT = GOLDEN * 64'(g);
        logic [63:0] s_raw;
        logic [63:0] s_ch;
        logic [18:0] c;

        assign s_raw = seed_q ^ SALT;
        assign s_ch  = (s_raw == '0) ? SUBST_SEED : s_raw;
        assign c     = sum_hats(st[g], HATS);
        assign samp[g*OUT_W +: OUT_W] = c[18 -: OUT_W];

        multihat_xorshift64 u_xs (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .load     (load),
            .seed     (s_ch),
            .step     (step),
            .state    (st[g])
        );
    end

    // Run-control FSM with registered handshake and sample outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            seed_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            warm_q  <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.ap_start) begin
                        seed_q  <= bus.seed_V;
                        burst_q <= bus.burst_len;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= SEED;
                    end
                end
                SEED: begin
                    warm_q  <= '0;
                    state_q <= WARM;
                end
                WARM: begin
                    warm_q <= warm_q + 16'd1;
                    if (warm_q == 16'(WARMUP - 1)) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (bus.ap_stop) begin
                        if (vld_q && bus.out_ready) begin
                            vld_q <= 1'b0;
                        end
                        state_q <= DRAIN;
                    end else if (launch) begin
                        out_q <= samp;
                        vld_q <= 1'b1;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                        if (burst_q != '0 &&
                            cnt_q + 16'd1 == burst_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!vld_q || bus.out_ready) begin
                        vld_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ap_idle      = (state_q == IDLE);
    assign bus.ap_ready     = ready_q;
    assign bus.ap_done      = done_q;
    assign bus.out_V        = out_q;
    assign bus.out_V_ap_vld = vld_q;
endmodule
